// File: rtl/queen_solver_ctrl.sv
// Backtracking sequencer for the 8-queens problem: one candidate per cycle, push/pop per column.
// Optional step counter enabled by defining QUEEN_STEP_COUNT_EN.
module queen_solver_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        next_i,
    output logic        busy_o,
    output logic        found_o,
    output logic        done_o,
    output logic [23:0] positions_o,
    output logic [6:0]  sol_count_o,
    output logic [15:0] step_count_o
);

    typedef enum logic [2:0] {StIdle, StTry, StPop, StSolved, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       d_q, d_d;
    logic [2:0]       r_q, r_d;
    logic [7:0][2:0]  pos_q, pos_d;
    logic [7:0]       row_used_q, row_used_d;
    logic [14:0]      diag_q, diag_d;
    logic [14:0]      anti_q, anti_d;
    logic [6:0]       sol_q, sol_d;

    function automatic logic [7:0] dec3to8(input logic [2:0] sel, input logic en);
        return en ? (8'd1 << sel) : 8'd0;
    endfunction

    function automatic logic [14:0] dec4to15(input logic [3:0] idx);
        logic [15:0] t;
        t = 16'd1 << idx;
        return t[14:0];
    endfunction

    logic        launch;
    logic        conflict;
    logic [3:0]  d_m1;
    logic [2:0]  pop_row;
    logic [7:0]  try_row_oh, pop_row_oh;
    logic [14:0] try_diag_oh, try_anti_oh, pop_diag_oh, pop_anti_oh;

    assign launch      = start_i && (state_q == StIdle || state_q == StDone);
    assign d_m1        = d_q - 4'd1;
    assign pop_row     = pos_q[d_m1[2:0]];
    assign try_row_oh  = dec3to8(r_q, 1'b1);
    assign pop_row_oh  = dec3to8(pop_row, 1'b1);
    // Diagonal indices stay within 0..14 in 4-bit arithmetic while d <= 7.
    assign try_diag_oh = dec4to15(d_q + {1'b0, r_q});
    assign try_anti_oh = dec4to15(d_q - {1'b0, r_q} + 4'd7);
    assign pop_diag_oh = dec4to15(d_m1 + {1'b0, pop_row});
    assign pop_anti_oh = dec4to15(d_m1 - {1'b0, pop_row} + 4'd7);
    assign conflict    = (|(try_row_oh & row_used_q)) | (|(try_diag_oh & diag_q))
                       | (|(try_anti_oh & anti_q));

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        r_d        = r_q;
        pos_d      = pos_q;
        row_used_d = row_used_q;
        diag_d     = diag_q;
        anti_d     = anti_q;
        sol_d      = sol_q;
        unique case (state_q)
            StTry: begin
                if (!conflict) begin
                    pos_d[d_q[2:0]] = r_q;
                    row_used_d      = row_used_q | try_row_oh;
                    diag_d          = diag_q | try_diag_oh;
                    anti_d          = anti_q | try_anti_oh;
                    d_d             = d_q + 4'd1;
                    r_d             = 3'd0;
                    if (d_q == 4'd7) begin
                        state_d = StSolved;
                        sol_d   = sol_q + 7'd1;
                    end
                end else if (r_q != 3'd7) begin
                    r_d = r_q + 3'd1;
                end else begin
                    state_d = StPop;
                end
            end
            StPop: begin
                if (d_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    d_d        = d_m1;
                    row_used_d = row_used_q & ~pop_row_oh;
                    diag_d     = diag_q & ~pop_diag_oh;
                    anti_d     = anti_q & ~pop_anti_oh;
                    if (pop_row != 3'd7) begin
                        r_d     = pop_row + 3'd1;
                        state_d = StTry;
                    end
                end
            end
            StSolved: begin
                if (next_i) state_d = StPop;
            end
            default: ;
        endcase
        if (launch) begin
            state_d    = StTry;
            d_d        = 4'd0;
            r_d        = 3'd0;
            row_used_d = '0;
            diag_d     = '0;
            anti_d     = '0;
            sol_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            d_q        <= '0;
            r_q        <= '0;
            pos_q      <= '0;
            row_used_q <= '0;
            diag_q     <= '0;
            anti_q     <= '0;
            sol_q      <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            r_q        <= r_d;
            pos_q      <= pos_d;
            row_used_q <= row_used_d;
            diag_q     <= diag_d;
            anti_q     <= anti_d;
            sol_q      <= sol_d;
        end
    end

`ifdef QUEEN_STEP_COUNT_EN
    logic [15:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (launch) begin
            step_d = '0;
        end else if (state_q == StTry && step_q != 16'hFFFF) begin
            step_d = step_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) step_q <= '0;
        else       step_q <= step_d;
    end

    assign step_count_o = step_q;
`else
    assign step_count_o = '0;
`endif

    assign busy_o      = (state_q == StTry) || (state_q == StPop);
    assign found_o     = (state_q == StSolved);
    assign done_o      = (state_q == StDone);
    assign positions_o = pos_q;
    assign sol_count_o = sol_q;

endmodule

// File: tb/tb_queen_solver_ctrl.sv
// Directed bench for queen_solver_ctrl: reset, first solution, handshake, exhaustion, ignored inputs.
module tb_queen_solver_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, next_i;
    logic        busy_o, found_o, done_o;
    logic [23:0] positions_o;
    logic [6:0]  sol_count_o;
    logic [15:0] step_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    queen_solver_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .next_i      (next_i),
        .busy_o      (busy_o),
        .found_o     (found_o),
        .done_o      (done_o),
        .positions_o (positions_o),
        .sol_count_o (sol_count_o),
        .step_count_o(step_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_to_found(input int lat0, output int lat);
        lat = lat0;
        while (found_o !== 1'b1 && lat < 20000) begin
            tick();
            lat++;
        end
        check("found_timeout", {31'd0, found_o}, 32'd1);
    endtask

    localparam logic [23:0] FirstSol = 24'h672BE0;
    localparam logic [23:0] LastSol  = 24'h98D41F;

    int          lat1, lat2, nfound, cyc;
    logic        stable;
    logic [23:0] hold_pos, last_pos;
    logic [15:0] hold_step;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; next_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_found", {31'd0, found_o}, 32'd0);
        check("rst_done",  {31'd0, done_o},  32'd0);
        check("rst_pos",   {8'd0, positions_o}, 32'd0);
        check("rst_sol",   {25'd0, sol_count_o}, 32'd0);
        check("rst_step",  {16'd0, step_count_o}, 32'd0);

        // Reset mid-search
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("start_busy",  {31'd0, busy_o},  32'd1);
        check("start_found", {31'd0, found_o}, 32'd0);
        repeat (50) tick();
        rst_i = 1'b1; repeat (3) tick(); rst_i = 1'b0;
        check("mid_rst_busy",  {31'd0, busy_o},  32'd0);
        check("mid_rst_found", {31'd0, found_o}, 32'd0);
        check("mid_rst_done",  {31'd0, done_o},  32'd0);
        check("mid_rst_pos",   {8'd0, positions_o}, 32'd0);
        check("mid_rst_sol",   {25'd0, sol_count_o}, 32'd0);
        tick();
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // First solution
        start_i = 1'b1; tick(); start_i = 1'b0;
        run_to_found(1, lat1);
        check("first_pos",   {8'd0, positions_o}, {8'd0, FirstSol});
        check("first_sol",   {25'd0, sol_count_o}, 32'd1);
        check("first_busy",  {31'd0, busy_o}, 32'd0);
        check("first_done",  {31'd0, done_o}, 32'd0);
`ifdef QUEEN_STEP_COUNT_EN
        check("step_nonzero", {31'd0, (step_count_o != 16'd0)}, 32'd1);
`else
        check("step_zero", {16'd0, step_count_o}, 32'd0);
`endif

        // Hold in SOLVED without next
        stable    = 1'b1;
        hold_step = step_count_o;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (found_o !== 1'b1 || positions_o !== FirstSol || step_count_o !== hold_step)
                stable = 1'b0;
        end
        check("solved_stable", {31'd0, stable}, 32'd1);

        next_i = 1'b1; tick(); next_i = 1'b0;
        check("next_found", {31'd0, found_o}, 32'd0);
        check("next_busy",  {31'd0, busy_o},  32'd1);

        // Exhaust the search, answering every solution
        nfound   = 1;
        last_pos = FirstSol;
        cyc      = 0;
        while (done_o !== 1'b1 && cyc < 60000) begin
            if (found_o === 1'b1) begin
                nfound++;
                check("sol_running", {25'd0, sol_count_o}, nfound);
                check("solved_busy", {31'd0, busy_o}, 32'd0);
                last_pos = positions_o;
                next_i = 1'b1; tick(); next_i = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        check("done_reached", {31'd0, done_o}, 32'd1);
        check("found_total",  nfound, 32'd92);
        check("done_sol",     {25'd0, sol_count_o}, 32'd92);
        check("done_busy",    {31'd0, busy_o}, 32'd0);
        check("done_found",   {31'd0, found_o}, 32'd0);
        check("last_pos",     {8'd0, last_pos}, {8'd0, LastSol});

        // next in DONE is ignored; outputs frozen
        hold_pos  = positions_o;
        hold_step = step_count_o;
        next_i = 1'b1; repeat (3) tick(); next_i = 1'b0;
        check("done_hold",      {31'd0, done_o}, 32'd1);
        check("done_hold_sol",  {25'd0, sol_count_o}, 32'd92);
        check("done_hold_pos",  {8'd0, positions_o}, {8'd0, hold_pos});
        check("done_hold_step", {16'd0, step_count_o}, {16'd0, hold_step});

        // start and next together in DONE: start wins
        start_i = 1'b1; next_i = 1'b1; tick(); start_i = 1'b0; next_i = 1'b0;
        check("restart_busy", {31'd0, busy_o}, 32'd1);
        check("restart_done", {31'd0, done_o}, 32'd0);
        check("restart_sol",  {25'd0, sol_count_o}, 32'd0);
        check("restart_step", {16'd0, step_count_o}, 32'd0);

        // start and next during TRY are ignored: same latency and result
        tick(); tick();
        start_i = 1'b1; next_i = 1'b1; tick(); start_i = 1'b0; next_i = 1'b0;
        run_to_found(4, lat2);
        check("ignored_latency", lat2, lat1);
        check("second_pos", {8'd0, positions_o}, {8'd0, FirstSol});
        check("second_sol", {25'd0, sol_count_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
